// File: rtl/asm_dp_scheduler.sv
// asm_dp_scheduler: round-robin arbiter sharing one x/y counter datapath
// between two requesters. Each granted operation runs the fixed sequence
// IDLE -> GRANT -> EXEC -> DONE and returns the captured x value on data_o.
//
// Ports:
//   clk_i    rising-edge clock
//   reset_i  asynchronous active-high reset
//   req_i    per-requester request (bit k = requester k), sampled in IDLE
//   inc_i    per-requester op select (1 = INC, 0 = READ), sampled with req_i
//   gnt_o    one-hot grant to the datapath owner (GRANT/EXEC/DONE)
//   done_o   one-cycle one-hot completion pulse to the owner (DONE)
//   data_o   y register: x value captured by the last completed operation
//   x_o      current x register value
//   busy_o   high whenever the FSM is not IDLE
module asm_dp_scheduler #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [1:0]       req_i,
  input  logic [1:0]       inc_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [WIDTH-1:0] data_o,
  output logic [WIDTH-1:0] x_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             owner_q, owner_d;
  logic             op_q, op_d;
  logic             prio_q, prio_d;
  logic             winner_c;
  logic [1:0]       gnt_d, done_d;
  logic             busy_d;

  // Tie goes to prio; otherwise the single requesting bit wins.
  assign winner_c = (req_i == 2'b11) ? prio_q : req_i[1];

  // Next-state, datapath and output decode.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    owner_d = owner_q;
    op_d    = op_q;
    prio_d  = prio_q;
    gnt_d   = 2'b00;
    done_d  = 2'b00;
    busy_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_i != 2'b00) begin
          owner_d = winner_c;
          op_d    = inc_i[winner_c];
          state_d = GRANT;
        end
      end
      GRANT: begin
        state_d = EXEC;
      end
      EXEC: begin
        y_d = x_q;
        if (op_q) begin
          x_d = x_q + WIDTH'(1);
        end
        state_d = DONE;
      end
      DONE: begin
        prio_d  = ~owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so decode them from the state being entered.
    if (state_d != IDLE) begin
      gnt_d  = 2'(1) << owner_d;
      busy_d = 1'b1;
    end
    if (state_d == DONE) begin
      done_d = 2'(1) << owner_d;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      owner_q <= 1'b0;
      op_q    <= 1'b0;
      prio_q  <= 1'b0;
      gnt_o   <= 2'b00;
      done_o  <= 2'b00;
      busy_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      owner_q <= owner_d;
      op_q    <= op_d;
      prio_q  <= prio_d;
      gnt_o   <= gnt_d;
      done_o  <= done_d;
      busy_o  <= busy_d;
    end
  end

  assign data_o = y_q;
  assign x_o    = x_q;

endmodule

// File: tb/tb_asm_dp_scheduler.sv
// Scoreboard bench for asm_dp_scheduler: a slot-based model predicts each
// operation's result at its sampling edge; a negedge monitor pops and
// compares whenever done_o pulses.
module tb_asm_dp_scheduler;

  localparam int unsigned WIDTH = 3;
  localparam int          XMOD  = 1 << WIDTH;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic [1:0]       req_i;
  logic [1:0]       inc_i;
  logic [1:0]       gnt_o;
  logic [1:0]       done_o;
  logic [WIDTH-1:0] data_o;
  logic [WIDTH-1:0] x_o;
  logic             busy_o;

  asm_dp_scheduler #(.WIDTH(WIDTH)) dut (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .req_i  (req_i),
    .inc_i  (inc_i),
    .gnt_o  (gnt_o),
    .done_o (done_o),
    .data_o (data_o),
    .x_o    (x_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int done;
    int data;
    int x;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  // Reference model: cycles left in the current 4-cycle slot, owner, x, last y.
  int m_rem, m_owner, m_x, m_y, m_prio;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rem = 0; m_owner = 0; m_x = 0; m_y = 0; m_prio = 0;
    q.delete();
  endtask

  // One sampling edge of the reference: a new operation starts only when no
  // slot is in progress; its result is fully known at this point.
  task automatic model_step();
    int   w;
    exp_t e;
    if (m_rem != 0) begin
      m_rem--;
    end else if (req_i != 2'b00) begin
      if (req_i == 2'b11) w = m_prio;
      else                w = (req_i == 2'b10) ? 1 : 0;
      e.done = 1 << w;
      e.data = m_x;
      m_y    = m_x;
      if (inc_i[w]) m_x = (m_x + 1) % XMOD;
      e.x     = m_x;
      q.push_back(e);
      m_owner = w;
      m_prio  = 1 - w;
      m_rem   = 3;
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_step();
    #1;
    chk("gnt", gnt_o, (m_rem != 0) ? (1 << m_owner) : 0);
    chk("busy", busy_o, (m_rem != 0) ? 1 : 0);
  endtask

  task automatic drive(input logic [1:0] r, input logic [1:0] i);
    req_i = r;
    inc_i = i;
  endtask

  task automatic do_op(input logic [1:0] r, input logic [1:0] i);
    drive(r, i);
    step();
    drive(2'b00, 2'b00);
    repeat (3) step();
  endtask

  task automatic apply_reset();
    reset_i = 1'b1;
    #1;
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_x", x_o, 0);
    chk("rst_data", data_o, 0);
    model_reset();
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  // Monitor: every done pulse must match the oldest predicted operation.
  always @(negedge clk_i) begin
    if (!reset_i && done_o != 2'b00) begin
      if (q.size() == 0) begin
        chk("unexpected_done", done_o, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done", done_o, e.done);
        chk("gnt_at_done", gnt_o, e.done);
        chk("data", data_o, e.data);
        chk("x_at_done", x_o, e.x);
      end
    end
  end

  initial begin
    reset_i = 1'b1;
    drive(2'b00, 2'b00);
    model_reset();
    #2;
    chk("init_gnt", gnt_o, 0);
    chk("init_busy", busy_o, 0);
    chk("init_x", x_o, 0);
    chk("init_data", data_o, 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    // Single INC from requester 0.
    do_op(2'b01, 2'b01);
    repeat (2) step();
    chk("single_inc_x", x_o, 1);

    // Both requesters INC continuously for 8 operations; x wraps to 0.
    @(posedge clk_i);
    #1;
    apply_reset();
    drive(2'b11, 2'b11);
    repeat (32) step();
    drive(2'b00, 2'b00);
    step();
    chk("wrap_x", x_o, 0);
    chk("wrap_data", data_o, 7);

    // Bring x to 5, then requester 1 READ.
    repeat (5) do_op(2'b01, 2'b01);
    do_op(2'b10, 2'b00);
    step();
    chk("read_x", x_o, 5);
    chk("read_data", data_o, 5);

    // Requester 0 drops req and toggles inc during GRANT; INC still completes.
    drive(2'b01, 2'b01);
    step();
    drive(2'b00, 2'b10);
    repeat (3) step();
    drive(2'b00, 2'b00);

    // Quiet period: nothing moves.
    repeat (10) begin
      step();
      chk("idle_x", x_o, m_x);
      chk("idle_data", data_o, m_y);
    end
    chk("idle_x_final", x_o, 6);

    // Reset during EXEC of an INC with x = 3.
    @(posedge clk_i);
    #1;
    apply_reset();
    repeat (3) do_op(2'b01, 2'b01);
    chk("pre_exec_x", x_o, 3);
    drive(2'b01, 2'b01);
    step();
    drive(2'b00, 2'b00);
    step();
    apply_reset();
    repeat (8) step();
    chk("post_rst_x", x_o, 0);
    chk("post_rst_data", data_o, 0);

    // Random traffic.
    repeat (400) begin
      drive(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      step();
    end
    drive(2'b00, 2'b00);
    repeat (8) step();
    chk("queue_drained", q.size(), 0);
    chk("final_x", x_o, m_x);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
